// File: rtl/dense_layer_seq_pkg.sv
// nn_parameters: shared layer constants, FSM encoding and the saturating adder
// used when DENSE_SAT_EN is defined.
package nn_parameters;
   localparam int IN_SIZE_1  = 26;
   localparam int OUT_SIZE_1 = 64;
   localparam int LANES_1    = 8;
   localparam int IN_W       = 16;
   localparam int W_W        = 8;
   localparam int ACC_W      = 24;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} dense_state_t;
`ifdef DENSE_SAT_EN
   function automatic longint sat_add(input longint a, input longint b, input int w);
      longint s, hi, lo;
      s  = a + b;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -hi - 1;
      return s > hi ? hi : s < lo ? lo : s;
   endfunction
`endif
endpackage

// File: rtl/dense_layer_seq_mac_lane.sv
// dense_mac_lane: one neuron accumulator; wraps by default, saturates each MAC
// step under DENSE_SAT_EN. Result is activated from the next-state value.
module dense_mac_lane #(
   parameter int IN_W  = nn_parameters::IN_W,
   parameter int W_W   = nn_parameters::W_W,
   parameter int ACC_W = nn_parameters::ACC_W,
   parameter int RELU  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_bias,
   input  logic                    mac_en,
   input  logic signed [IN_W-1:0]  x,
   input  logic signed [W_W-1:0]   w,
   input  logic signed [W_W-1:0]   b,
   output logic signed [ACC_W-1:0] y
);
`ifdef DENSE_SAT_EN
   import nn_parameters::*;
`endif
   logic signed [IN_W+W_W-1:0] p;
   logic signed [ACC_W-1:0] acc, prod, sum, nxt;
   assign p = x * w;
   assign prod = ACC_W'(p);
   always_comb begin
`ifdef DENSE_SAT_EN
      sum = ACC_W'(sat_add(longint'(acc), longint'(prod), ACC_W));
`else
      sum = acc + prod;
`endif
      nxt = load_bias ? ACC_W'(b) : mac_en ? sum : acc;
      y   = (RELU != 0 && nxt[ACC_W-1]) ? '0 : nxt;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) acc <= '0;
      else acc <= nxt;
endmodule

// File: rtl/dense_layer_seq.sv
// dense_layer_seq: sequential fully-connected layer, LANES neurons per pass over
// a synchronous weight ROM. DENSE_SAT_EN selects saturating accumulation.
module dense_layer_seq #(
   parameter int IN_SIZE  = nn_parameters::IN_SIZE_1,
   parameter int OUT_SIZE = nn_parameters::OUT_SIZE_1,
   parameter int LANES    = nn_parameters::LANES_1,
   parameter int IN_W     = nn_parameters::IN_W,
   parameter int W_W      = nn_parameters::W_W,
   parameter int ACC_W    = nn_parameters::ACC_W,
   parameter int RELU     = 1,
   localparam int NGROUP  = OUT_SIZE / LANES,
   localparam int ADDR_W  = $clog2(NGROUP * (IN_SIZE + 1))
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [IN_SIZE-1:0][IN_W-1:0]     input_vector,
   output logic                             w_rd_en,
   output logic [ADDR_W-1:0]                w_addr,
   input  logic [LANES*W_W-1:0]             w_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [OUT_SIZE-1:0][ACC_W-1:0]   output_vector,
   output logic                             busy
);
   import nn_parameters::*;
   localparam int KW = $clog2(IN_SIZE + 1);
   localparam int GW = NGROUP > 1 ? $clog2(NGROUP) : 1;
   dense_state_t state, nxt_state;
   logic [KW-1:0] k, kd;
   logic [GW-1:0] grp;
   logic [ADDR_W-1:0] addr;
   logic dv;
   logic [IN_SIZE-1:0][IN_W-1:0] x_reg;
   logic [IN_W-1:0] xsel;
   logic [LANES-1:0][ACC_W-1:0] y;
   always_comb begin
      nxt_state = state == IDLE  ? (in_valid ? RUN : IDLE) :
                  state == RUN   ? (k == KW'(IN_SIZE) ? DRAIN : RUN) :
                  state == DRAIN ? (grp == GW'(NGROUP - 1) ? DONE : RUN) :
                  (out_ready ? IDLE : DONE);
      in_ready  = state == IDLE;
      w_rd_en   = state == RUN;
      busy      = state == RUN || state == DRAIN;
      out_valid = state == DONE;
      w_addr    = addr;
      xsel      = kd == '0 ? '0 : x_reg[kd - KW'(1)];
   end
   // The ROM is laid out contiguously per group, so one running address suffices.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state         <= IDLE;
         k             <= '0;
         kd            <= '0;
         grp           <= '0;
         addr          <= '0;
         dv            <= 1'b0;
         x_reg         <= '0;
         output_vector <= '0;
      end else begin
         state <= nxt_state;
         dv    <= w_rd_en;
         kd    <= k;
         if (state == IDLE && in_valid) begin
            x_reg <= input_vector;
            grp   <= '0;
            k     <= '0;
            addr  <= '0;
         end
         if (state == RUN) begin
            k    <= k + KW'(1);
            addr <= addr + ADDR_W'(1);
         end
         if (state == DRAIN) begin
            k <= '0;
            if (grp != GW'(NGROUP - 1)) grp <= grp + GW'(1);
            for (int j = 0; j < LANES; j++) output_vector[int'(grp) * LANES + j] <= y[j];
         end
      end
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      dense_mac_lane #(.IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W), .RELU(RELU)) u_lane (
         .clk(clk), .rst(rst),
         .load_bias(dv && kd == '0), .mac_en(dv && kd != '0),
         .x(xsel), .w(w_data[l*W_W +: W_W]), .b(w_data[l*W_W +: W_W]), .y(y[l]));
   end
endmodule

// File: tb/tb_dense_layer_seq.sv
// tb_dense_layer_seq: directed checks of dense_layer_seq on a small config (both
// activations) and the default config; DENSE_SAT_EN changes the overflow expectation.
module tb_dense_layer_seq;
   logic clk = 0, rst = 0;
   always #5 clk = ~clk;
   int total = 0, bad = 0;
`ifdef DENSE_SAT_EN
   localparam bit SAT = 1;
`else
   localparam bit SAT = 0;
`endif
   logic s_iv = 0, s_or = 0;
   logic [2:0][15:0] s_x = '0;
   logic a_ir, a_rd, a_ov, a_busy, b_ir, b_rd, b_ov, b_busy;
   logic [2:0] a_addr, b_addr;
   logic [15:0] a_data = '0, b_data = '0;
   logic [3:0][23:0] a_out, b_out;
   int s_b = 0, s_w = 0;
   logic c_iv = 0, c_or = 0, c_ir, c_rd, c_ov, c_busy;
   logic [25:0][15:0] c_x = '0, gx;
   logic [7:0] c_addr;
   logic [63:0] c_data = '0;
   logic [63:0][23:0] c_out;
   int c_b = 0, c_w = 0;
   bit c_mode = 0;
   int lat;

   dense_layer_seq #(.IN_SIZE(3), .OUT_SIZE(4), .LANES(2), .RELU(1)) dut_a (
      .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(a_ir), .input_vector(s_x),
      .w_rd_en(a_rd), .w_addr(a_addr), .w_data(a_data), .out_valid(a_ov),
      .out_ready(s_or), .output_vector(a_out), .busy(a_busy));
   dense_layer_seq #(.IN_SIZE(3), .OUT_SIZE(4), .LANES(2), .RELU(0)) dut_b (
      .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(b_ir), .input_vector(s_x),
      .w_rd_en(b_rd), .w_addr(b_addr), .w_data(b_data), .out_valid(b_ov),
      .out_ready(s_or), .output_vector(b_out), .busy(b_busy));
   dense_layer_seq dut_c (
      .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .input_vector(c_x),
      .w_rd_en(c_rd), .w_addr(c_addr), .w_data(c_data), .out_valid(c_ov),
      .out_ready(c_or), .output_vector(c_out), .busy(c_busy));

   function automatic int pat(input int a, input int l);
      return ((a * 3 + l) % 7) - 3;
   endfunction
   function automatic logic [15:0] rom_s(input logic [2:0] a);
      logic [7:0] v;
      v = (a % 4 == 0) ? 8'(s_b) : 8'(s_w);
      return {v, v};
   endfunction
   function automatic logic [63:0] rom_c(input logic [7:0] a);
      logic [63:0] r;
      for (int l = 0; l < 8; l++)
         r[l*8 +: 8] = 8'(c_mode ? pat(int'(a), l) : (int'(a) % 27 == 0 ? c_b : c_w));
      return r;
   endfunction
   always @(posedge clk) begin
      if (a_rd) a_data <= rom_s(a_addr);
      if (b_rd) b_data <= rom_s(b_addr);
      if (c_rd) c_data <= rom_c(c_addr);
   end

   function automatic longint gold(input int n, input logic [25:0][15:0] xv);
      int g, l, base;
      longint acc;
      logic [23:0] t;
      g = n / 8; l = n % 8; base = g * 27;
      acc = c_mode ? pat(base, l) : c_b;
      for (int i = 0; i < 26; i++) begin
         acc += longint'($signed(xv[i])) * longint'(c_mode ? pat(base + 1 + i, l) : c_w);
         if (SAT) acc = acc > 8388607 ? 8388607 : acc < -8388608 ? -8388608 : acc;
         else begin
            t = acc[23:0];
            acc = longint'($signed(t));
         end
      end
      return acc < 0 ? 0 : acc;
   endfunction

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic go_small(output int n);
      @(negedge clk) s_iv = 1;
      @(negedge clk) s_iv = 0;
      n = 0;
      while (!a_ov && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic go_c(input bit mon, output int n);
      int ea;
      ea = 0;
      @(negedge clk) c_iv = 1;
      @(negedge clk) c_iv = 0;
      if (mon) c_x = '0;
      n = 0;
      while (!c_ov && n < 300) begin
         if (mon) begin
            chk("rd_en", longint'(c_rd), longint'((n % 28) != 27));
            if (c_rd) begin
               chk("addr", longint'(c_addr), longint'(ea));
               ea++;
            end
         end
         @(negedge clk);
         n++;
      end
      if (mon) begin
         chk("rd_done", longint'(c_rd), 0);
         chk("rd_count", longint'(ea), 216);
      end
   endtask

   task automatic release_c();
      c_or = 1;
      @(negedge clk) c_or = 0;
      chk("c_ov_fall", longint'(c_ov), 0);
      chk("c_ir_back", longint'(c_ir), 1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_c_out", longint'(c_out == '0), 1);
      chk("rst_a_out", longint'(a_out == '0), 1);
      chk("rst_rd", longint'(c_rd), 0);
      chk("rst_addr", longint'(c_addr), 0);
      chk("rst_ov", longint'(c_ov), 0);
      chk("rst_busy", longint'(c_busy), 0);
      rst = 1;
      @(negedge clk);
      chk("rst_ir", longint'(c_ir), 1);
      chk("rst_a_ir", longint'(a_ir), 1);
      // bias and MAC across groups
      s_b = 5; s_w = 1;
      s_x[0] = 16'd1; s_x[1] = 16'd2; s_x[2] = 16'd3;
      go_small(lat);
      chk("lat_small", longint'(lat), 10);
      chk("b_ov", longint'(b_ov), 1);
      chk("a_busy_done", longint'(a_busy), 0);
      for (int n = 0; n < 4; n++) begin
         chk("a_sum", longint'($signed(a_out[n])), 11);
         chk("b_sum", longint'($signed(b_out[n])), 11);
      end
      s_or = 1;
      @(negedge clk) s_or = 0;
      chk("a_ov_fall", longint'(a_ov), 0);
      chk("a_ir_back", longint'(a_ir), 1);
      // activation modes, then backpressure
      s_b = 0; s_w = -2;
      go_small(lat);
      chk("lat_small2", longint'(lat), 10);
      for (int n = 0; n < 4; n++) begin
         chk("a_relu", longint'($signed(a_out[n])), 0);
         chk("b_lin", longint'($signed(b_out[n])), -12);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         s_iv = (i % 3 == 0);
         s_x[0] = 16'(i);
         s_w = 3;
      end
      s_iv = 0;
      chk("bp_ov", longint'(a_ov), 1);
      chk("bp_ir", longint'(a_ir), 0);
      chk("bp_busy", longint'(a_busy), 0);
      for (int n = 0; n < 4; n++) chk("bp_hold", longint'($signed(b_out[n])), -12);
      s_or = 1;
      @(negedge clk) s_or = 0;
      chk("bp_ov_fall", longint'(a_ov), 0);
      chk("bp_ir_back", longint'(a_ir), 1);
      @(negedge clk);
      chk("bp_no_start", longint'(a_busy), 0);
      // overflow at defaults, address sequence, input changes ignored
      c_mode = 0; c_b = 0; c_w = 127;
      for (int i = 0; i < 26; i++) c_x[i] = 16'd32767;
      gx = c_x;
      go_c(1, lat);
      chk("lat_def", longint'(lat), 224);
      chk("ovf_0", longint'($signed(c_out[0])), SAT ? 8388607 : 7533338);
      for (int n = 1; n < 64; n += 9) chk("ovf", longint'($signed(c_out[n])), gold(n, gx));
      release_c();
      // reset mid-run, then a patterned transaction against the model
      c_mode = 1;
      for (int i = 0; i < 26; i++) c_x[i] = 16'((i % 9) * 37 - 150);
      @(negedge clk) c_iv = 1;
      @(negedge clk) c_iv = 0;
      repeat (49) @(negedge clk);
      rst = 0;
      #1;
      chk("mid_rst_busy", longint'(c_busy), 0);
      @(negedge clk) rst = 1;
      @(negedge clk);
      chk("mid_rst_out", longint'(c_out == '0), 1);
      chk("mid_rst_ir", longint'(c_ir), 1);
      for (int i = 0; i < 26; i++) c_x[i] = 16'(120 - (i % 7) * 41);
      gx = c_x;
      go_c(0, lat);
      chk("lat_pat", longint'(lat), 224);
      for (int n = 0; n < 64; n++) chk("pat_out", longint'($signed(c_out[n])), gold(n, gx));
      release_c();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dense_layer_seq.md
Name: dense_layer_seq

Overview:
- Parametrised sequential fully-connected layer for the speech-recognition network. Computes y = act(W·x + b) over IN_SIZE inputs and OUT_SIZE neurons.
- Processes LANES neurons in parallel per cycle, fetching weights and bias from an external synchronous ROM.
- Uses valid/ready handshakes on input and output, so layers chain into a pipeline.
- Adds bias exactly once per neuron.
- ReLU is selectable.

Parameters:
- IN_SIZE, 26, input vector length
- OUT_SIZE, 64, neuron count; must be a multiple of LANES
- LANES, 8, neurons computed in parallel
- IN_W, 16, signed input width
- W_W, 8, signed weight/bias width
- ACC_W, 24, signed accumulator/output width
- RELU, 1, 1 = clamp negative outputs to 0; 0 = linear output
- NGROUP (localparam), OUT_SIZE/LANES
- ADDR_W (localparam), $clog2(NGROUP*(IN_SIZE+1))

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- in_valid  in  1  input vector valid
- in_ready  out  1  high only in IDLE
- input_vector  in  IN_SIZE x IN_W  signed inputs
- w_rd_en  out  1  ROM read enable
- w_addr  out  ADDR_W  ROM word address
- w_data  in  LANES*W_W  ROM word; lane l occupies bits [l*W_W +: W_W]; valid 1 cycle after w_rd_en
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- output_vector  out  OUT_SIZE x ACC_W  signed results
- busy  out  1  high in RUN or DRAIN

Behaviour:
- Reset (rst low, async), regardless of state:
  - state goes to IDLE.
  - output_vector, accumulators, counters, w_addr are 0.
  - w_rd_en=0, out_valid=0, busy=0.
  - in_ready=1 once rst is high.
- ROM layout per group g: word g*(IN_SIZE+1) holds the LANES biases; words g*(IN_SIZE+1)+1+i hold the weights of input i for neurons g*LANES..g*LANES+LANES-1.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid, latch input_vector into an internal register, set g=0 and k=0, go to RUN.
- RUN (IN_SIZE+1 cycles):
  - w_rd_en=1, w_addr=g*(IN_SIZE+1)+k; k increments each cycle.
  - Go to DRAIN after k=IN_SIZE.
- Data path (pipeline: index k delayed by one, kd):
  - kd=0: acc[l] = sext(bias lane l).
  - kd>0: acc[l] = acc[l] + sext(x[kd-1]*w lane l).
  - Product is IN_W+W_W signed.
  - Accumulation wraps modulo 2^ACC_W.
- DRAIN (1 cycle):
  - w_rd_en=0.
  - Last data word is accumulated.
  - output_vector[g*LANES+l] is written with act(acc[l]) at the end of this cycle.
  - If g<NGROUP-1: g++, k=0, go to RUN. Otherwise go to DONE.
- DONE:
  - out_valid=1.
  - output_vector is held stable.
  - in_ready=0, so in_valid is ignored.
  - When out_ready: go to IDLE; out_valid falls next cycle.
  - No new input is accepted in the same cycle as out_ready.
- Latency: out_valid rises exactly NGROUP*(IN_SIZE+2) cycles after the accepting edge (224 at defaults).
- output_vector retains its last result through IDLE until overwritten group-by-group by the next transaction.
- act(): RELU=1 → value<0 gives 0; RELU=0 → identity.
- Changes on input_vector after acceptance have no effect.

Optional Feature:
- Macro: DENSE_SAT_EN.
- Defined: every accumulate step saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Bias load is unaffected.
- Undefined: two's-complement wrap as above. No saturation logic is synthesised.

Decomposition:
- Package nn_parameters gains:
  - layer constants (IN_SIZE_1, OUT_SIZE_1, LANES_1)
  - IN_W, W_W, ACC_W
  - enum dense_state_t {IDLE, RUN, DRAIN, DONE}
  - function sat_add() used under DENSE_SAT_EN
- Sub-module dense_mac_lane:
  - one lane's accumulator
  - inputs: load_bias, mac_en, x, w, b
  - output: activated result
  - instantiated LANES times via generate
- Top level holds the FSM, counters, address generation and the input/output registers.

Test Plan:
1. Bias and MAC across groups. IN_SIZE=3, OUT_SIZE=4, LANES=2; all biases 5, all weights 1; x={1,2,3} → all outputs 11; out_valid exactly 10 cycles after accept.
2. Activation mode. Same config, weights -2, bias 0 (sum -12). RELU=1 → outputs 0. RELU=0 → outputs -12.
3. Output backpressure. Hold out_ready low 20 cycles after out_valid, pulse in_valid meanwhile → output_vector stable, in_ready=0, no new transaction starts. Raise out_ready → IDLE next cycle.
4. Overflow at defaults. All x=32767, all w=127, bias 0, RELU=1 → without DENSE_SAT_EN outputs 7533338 (wrapped); with it outputs 8388607.
5. Reset mid-run. Drop rst at cycle 50 of a transaction → all outputs 0 and in_ready=1 immediately after release; the next transaction matches the golden model.
6. Address sequence. Monitor w_addr/w_rd_en at defaults → 0..26 for g=0, 27..53 for g=1, … 189..215 for g=7; w_rd_en low in DRAIN, IDLE and DONE.
